// File: rtl/ram_access_ctrl.sv
// CPU load/store front-end for the single-port word RAM. It handles sub-word lane
// extraction on loads and performs read-modify-write for byte and half stores.
module ram_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    // state    | meaning
    // IDLE     | waiting for a request; only state with req_ready
    // RD_ISSUE | mem_read strobe high
    // RD_WAIT  | RAM data arriving; extract (load) or merge (sub-word store)
    // WR_ISSUE | mem_write strobe high
    // RESP     | one-cycle response pulse
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [1:0]            r_lane;
    logic [1:0]            r_size;
    logic                  r_write;
    logic                  r_unsigned;
    logic [15:0]           r_wdata;
    logic                  w_accept;
    logic                  w_err;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_val;
    logic [DATA_WIDTH-1:0] w_merged;

    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_err = (req_size == 2'b11)
             || ((req_size == 2'b01) && req_addr[0])
             || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err)                                 w_state_next = RESP;
                    else if (req_write && req_size == 2'b10)   w_state_next = WR_ISSUE;
                    else                                       w_state_next = RD_ISSUE;
                end
            end
            RD_ISSUE: w_state_next = RD_WAIT;
            RD_WAIT:  w_state_next = r_write ? WR_ISSUE : RESP;
            WR_ISSUE: w_state_next = RESP;
            RESP:     w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_byte     = mem_data_out[{r_lane, 3'b000} +: 8];
        w_half     = mem_data_out[{r_lane[1], 4'b0000} +: 16];
        w_load_val = mem_data_out;
        case (r_size)
            2'b00:   w_load_val = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_val = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_val = mem_data_out;
        endcase
        w_merged = mem_data_out;
        if (r_size == 2'b00) w_merged[{r_lane, 3'b000} +: 8]     = r_wdata[7:0];
        else                 w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end

    // Strobes are registered copies of the state being entered, so each is a single
    // cycle per state visit and read/write can never overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_error  <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
            r_lane      <= '0;
            r_size      <= '0;
            r_write     <= 1'b0;
            r_unsigned  <= 1'b0;
            r_wdata     <= '0;
        end else begin
            mem_read   <= (w_state_next == RD_ISSUE);
            mem_write  <= (w_state_next == WR_ISSUE);
            resp_valid <= (w_state_next == RESP);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_lane      <= req_addr[1:0];
                        r_size      <= req_size;
                        r_write     <= req_write;
                        r_unsigned  <= req_unsigned;
                        r_wdata     <= req_wdata[15:0];
                        mem_address <= req_addr[ADDR_WIDTH+1:2];
                        resp_rdata  <= '0;
                        resp_error  <= w_err;
                        if (req_write && req_size == 2'b10) mem_data_in <= req_wdata;
                    end
                end
                RD_WAIT: begin
                    if (r_write) mem_data_in <= w_merged;
                    else         resp_rdata  <= w_load_val;
                end
                RESP:    resp_error <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
Initiator-side controller that drives the single-port word RAM (`ram`) on behalf of the CPU load/store path. It accepts byte-addressed byte, half and word load/store requests over a valid/ready handshake, and issues word-wide RAM read/write cycles. Loads are sign- or zero-extended; sub-word stores use read-modify-write. The block sits between the CPU memory stage and `ram`.

Parameters:
DATA_WIDTH, 32, RAM word width; fixed at 32 for byte-lane logic.
ADDR_WIDTH, 16, RAM word-address width.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept (combinational: state==IDLE && !rst)
req_write  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  load result; 0 for stores and errors
resp_error  out  1  misaligned or illegal size, valid with resp_valid
mem_address  out  ADDR_WIDTH  RAM word address = req_addr[ADDR_WIDTH+1:2]
mem_data_in  out  32  RAM write data
mem_write  out  1  RAM write strobe
mem_read  out  1  RAM read strobe
mem_data_out  in  32  RAM read data, valid the cycle after the edge that samples mem_read

Behaviour:
- Reset: state=IDLE; resp_valid, resp_error, mem_write, mem_read = 0; resp_rdata, mem_address, mem_data_in = 0; captured request cleared. req_ready=0 while rst=1.
- Reset mid-operation: abort immediately, with no response and no further mem strobes. A pending sub-word store never writes.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP. All mem_* and resp_* outputs are registered.
- IDLE: on req_valid&&req_ready at edge E0, latch addr, size, write, unsigned and wdata. mem_address is held from E0 until leaving RESP.
- Error check at accept: half with addr[0]=1, word with addr[1:0]!=0, or size=11. Next state RESP with resp_error=1; no mem strobe asserted.
- Word store: IDLE→WR_ISSUE (mem_write=1, mem_data_in=wdata, one cycle)→RESP. resp_valid is high the cycle after E1.
- Load: IDLE→RD_ISSUE (mem_read=1, one cycle)→RD_WAIT (capture mem_data_out at E2)→RESP. resp_valid is high the cycle after E2.
- Sub-word store: IDLE→RD_ISSUE→RD_WAIT (capture, then merge)→WR_ISSUE (merged word)→RESP. resp_valid is high the cycle after E3.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Extraction:
  - byte lane = addr[1:0] (lane0 = bits 7:0);
  - half lane = addr[1] (0→15:0, 1→31:16);
  - extend per req_unsigned;
  - word: unmodified.
- Merge: byte replaces lane addr[1:0] with wdata[7:0]; half replaces the addressed half with wdata[15:0]; other lanes keep the read value.
- mem_read and mem_write are never both 1. Each strobe is high for at most one cycle per state visit.
- req_addr bits above ADDR_WIDTH+1 are ignored (address aliases/wraps).
- Back-to-back: req_ready is low in all non-IDLE states. The earliest next accept is the IDLE cycle following RESP.

Test Plan:
1. Word store 0xDEADBEEF @0x00000010 → mem_address=0x0004, mem_write for 1 cycle, resp_valid 2 cycles after accept. A word load @0x10 then gives mem_read for 1 cycle and resp_rdata=0xDEADBEEF, resp_valid 3 cycles after accept.
2. Loads with the RAM word=0xDEADBEEF:
   - byte @0x11 signed → 0xFFFFFFBE;
   - byte @0x11 unsigned → 0x000000BE;
   - half @0x12 signed → 0xFFFFDEAD;
   - half @0x10 unsigned → 0x0000BEEF.
3. Byte store 0x55 @0x13 → exactly one mem_read then one mem_write with data 0x55ADBEEF, resp at 4 cycles. A following half store 0x1234 @0x10 leaves the word reading 0x55AD1234.
4. Word load @0x00000011, half store @0x03, and size=11 → each gives resp_error=1 with resp_valid the cycle after accept and resp_rdata=0. mem_read and mem_write stay 0 throughout.
5. rst pulsed during RD_WAIT of a byte store → no mem_write and no resp_valid. req_ready=1 the first cycle after rst falls. A subsequent word load returns the old value.
6. req_valid held high with 4 queued requests (store, load, byte store, load) → each accepted exactly once, req_ready=0 outside IDLE. 4 resp pulses arrive in order with correct data. Word store @0x00040010 aliases to mem_address 0x0004.
